// File: rtl/acos_fix_iter_pkg.sv
// Shared constants, types and helpers for the iterative arccos unit.
package acos_fix_iter_pkg;

  localparam int FRAC_DEF = 30;
  localparam int ITER_DEF = 24;
  // Fraction bits of the stored constants below; narrower datapaths shift them down.
  localparam int TBL_FRAC = 30;

  localparam logic [31:0] PI_F   = 32'h40490fdb;
  localparam logic [31:0] PI_2_F = 32'h3fc90fdb;
  localparam logic [31:0] QNAN_F = 32'h7fc00000;
  localparam logic [31:0] ONE_F  = 32'h3f800000;

  // pi and pi/2 in Q2.TBL_FRAC
  localparam logic [31:0] PI_FIX   = 32'hc90fdaa2;
  localparam logic [31:0] PI_2_FIX = 32'h6487ed51;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_SQRT,
    S_CORDIC,
    S_PACK,
    S_DONE
  } state_t;

  // Operands resolved without the iterative path.
  typedef struct packed {
    logic        hit;
    logic        err;
    logic [31:0] val;
  } special_t;

  // atan(2^-i) in Q2.TBL_FRAC, truncated.
  function automatic logic [31:0] atan_q30(input int i);
    logic [31:0] v;
    case (i)
      0:  v = 32'h3243f6a8;
      1:  v = 32'h1dac6705;
      2:  v = 32'h0fadbafc;
      3:  v = 32'h07f56ea6;
      4:  v = 32'h03feab76;
      5:  v = 32'h01ffd55b;
      6:  v = 32'h00fffaaa;
      7:  v = 32'h007fff55;
      8:  v = 32'h003fffea;
      9:  v = 32'h001ffffd;
      default: v = (i < 30) ? ((32'h1 << (30 - i)) - 32'h1) : 32'h0;
    endcase
    return v;
  endfunction

  // Classify the operand: exact +/-1, zeros/denormals, and out-of-domain values.
  function automatic special_t classify(input logic [31:0] v);
    special_t s;
    s = '0;
    if (v[30:23] == 8'hff) begin
      s.hit = 1'b1;
      s.err = 1'b1;
      s.val = QNAN_F;
    end else if (v[30:0] == ONE_F[30:0]) begin
      s.hit = 1'b1;
      s.val = v[31] ? PI_F : 32'h0;
    end else if (v[30:23] == 8'h00) begin
      s.hit = 1'b1;
      s.val = PI_2_F;
    end else if (v[30:23] >= 8'd127) begin
      s.hit = 1'b1;
      s.err = 1'b1;
      s.val = QNAN_F;
    end
    return s;
  endfunction

endpackage

// File: rtl/acos_fix_iter_isqrt.sv
// Bit-serial non-restoring integer square root, one root bit per cycle.
// The first bit is resolved on the load edge, so done follows start by N edges.
module isqrt_iter #(
  parameter int N = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*N-1:0]  rad,
  output logic            done,
  output logic [N-1:0]    root
);
  localparam int RW = 2 * N + 2;
  localparam int CW = $clog2(N) + 1;

  logic [2*N-1:0]        rad_r;
  logic signed [RW-1:0]  rem_r;
  logic [N-1:0]          q_r;
  logic [CW-1:0]         cnt;
  logic                  run;

  logic signed [RW-1:0]  rem_in, rem_nx, tq;
  logic [N-1:0]          q_in, q_nx;
  logic [1:0]            d2;

  // One non-restoring step; on load it starts from a zero remainder/root.
  always_comb begin
    rem_in = start ? '0 : rem_r;
    q_in   = start ? '0 : q_r;
    d2     = start ? rad[2*N-1:2*N-2] : rad_r[2*N-1:2*N-2];
    rem_nx = (rem_in <<< 2) | RW'(d2);
    if (!rem_in[RW-1]) begin
      tq     = RW'({q_in, 2'b01});
      rem_nx = rem_nx - tq;
    end else begin
      tq     = RW'({q_in, 2'b11});
      rem_nx = rem_nx + tq;
    end
    q_nx = N'({q_in, ~rem_nx[RW-1]});
  end

  // Iteration state and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad_r <= '0;
      rem_r <= '0;
      q_r   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_r <= rem_nx;
        q_r   <= q_nx;
        rad_r <= rad << 2;
        cnt   <= CW'(1);
        run   <= 1'b1;
      end else if (run) begin
        rem_r <= rem_nx;
        q_r   <= q_nx;
        rad_r <= rad_r << 2;
        cnt   <= cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign root = q_r;

endmodule

// File: rtl/acos_fix_iter.sv
// Iterative arccos of an IEEE-754 single: unpack to Q2.FRAC, sqrt(1-x^2),
// CORDIC vectoring atan2(sqrt, |x|), mirror for negative x, pack to single.
module acos_fix_iter
  import acos_fix_iter_pkg::*;
#(
  parameter int FRAC = FRAC_DEF,
  parameter int ITER = ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x,
  output logic        busy,
  output logic        done,
  output logic [31:0] theta,
  output logic        err
);
  localparam int W    = FRAC + 3;
  localparam int N    = FRAC + 1;
  localparam int RADW = 2 * N;
  localparam int CW   = $clog2(ITER) + 1;
  localparam logic signed [W-1:0] PI_W = W'(PI_FIX >> (TBL_FRAC - FRAC));

  state_t state, state_nx;

  logic [31:0]          x_r;
  logic                 sign_r;
  logic [W-1:0]         m_r;
  special_t             spec, spec_r;
  logic signed [W-1:0]  cx, cy, cz;
  logic [CW-1:0]        it;

  logic                 accept;
  logic [7:0]           sh;
  logic [W-1:0]         m_comb;
  logic [RADW-1:0]      rad;
  logic                 sq_start, sq_done;
  logic [N-1:0]         sq_root;

  logic signed [W-1:0]  xs, ys, atan_w, cx_nx, cy_nx, cz_nx;
  logic signed [W-1:0]  a_s;
  logic [W-1:0]         a, norm;
  int                   p;
  logic [31:0]          pack_f;

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign busy   = (state != S_IDLE) && (state != S_DONE);
  assign done   = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state; specials ride through PACK with their precomputed result.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: state_nx = accept ? S_UNPACK : S_IDLE;
      S_UNPACK:       state_nx = spec.hit ? S_PACK : S_SQRT;
      S_SQRT:         if (sq_done) state_nx = S_CORDIC;
      S_CORDIC:       if (it == CW'(ITER - 1)) state_nx = S_PACK;
      S_PACK:         state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Unpack: special classification, |x| in Q2.FRAC (truncated), radicand 1-m^2.
  always_comb begin
    spec   = classify(x_r);
    sh     = 8'd127 - x_r[30:23];
    m_comb = W'((64'({1'b1, x_r[22:0]}) << FRAC) >> (32'd23 + 32'(sh)));
    rad    = (RADW'(1) << (2 * FRAC)) - RADW'(m_comb) * RADW'(m_comb);
  end

  assign sq_start = (state == S_UNPACK) && !spec.hit;

  isqrt_iter #(.N(N)) u_sqrt (
    .clk   (clk),
    .rst   (rst),
    .start (sq_start),
    .rad   (rad),
    .done  (sq_done),
    .root  (sq_root)
  );

  // One vectoring micro-rotation driving Y toward zero, accumulating angle in Z.
  always_comb begin
    xs     = cx >>> it;
    ys     = cy >>> it;
    atan_w = W'(atan_q30(int'(it)) >> (TBL_FRAC - FRAC));
    if (!cy[W-1]) begin
      cx_nx = cx + ys;
      cy_nx = cy - xs;
      cz_nx = cz + atan_w;
    end else begin
      cx_nx = cx - ys;
      cy_nx = cy + xs;
      cz_nx = cz - atan_w;
    end
  end

  // Pack: mirror for negative x, leading-one detect, truncate to 23 mantissa bits.
  always_comb begin
    a_s = sign_r ? (PI_W - cz) : cz;
    a   = a_s[W-1] ? '0 : a_s;
    p   = 0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) p = i;
    end
    norm   = a << (W - 1 - p);
    pack_f = {1'b0, 8'(p + 127 - FRAC), 23'(norm >> (W - 24))};
    if (a == '0)  pack_f = 32'h0;
    if (spec_r.hit) pack_f = spec_r.val;
  end

  // Operand capture, CORDIC registers and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r    <= '0;
      sign_r <= 1'b0;
      m_r    <= '0;
      spec_r <= '0;
      cx     <= '0;
      cy     <= '0;
      cz     <= '0;
      it     <= '0;
      theta  <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) x_r <= x;
      if (state == S_UNPACK) begin
        spec_r <= spec;
        sign_r <= x_r[31];
        m_r    <= m_comb;
      end
      if (state == S_SQRT && sq_done) begin
        cx <= m_r;
        cy <= W'(sq_root);
        cz <= '0;
        it <= '0;
      end
      if (state == S_CORDIC) begin
        cx <= cx_nx;
        cy <= cy_nx;
        cz <= cz_nx;
        it <= it + CW'(1);
      end
      if (state == S_PACK) begin
        theta <= pack_f;
        err   <= spec_r.err;
      end
    end
  end

endmodule

// File: tb/tb_acos_fix_iter.sv
// Self-checking bench for acos_fix_iter: vector table, corner sequences,
// randomized sweeps against a real-arithmetic arccos model.
module tb_acos_fix_iter;
  localparam int FRAC  = 30;
  localparam int ITER  = 24;
  localparam int LAT_N = FRAC + ITER + 3;
  localparam int LAT_S = 2;
  localparam logic [31:0] JUNK = 32'h7fc00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x = '0;
  logic        busy, done, err;
  logic [31:0] theta;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] x;
    logic        special;
    logic [31:0] th;
    logic        er;
  } vec_t;

  vec_t tbl [0:17];

  acos_fix_iter #(.FRAC(FRAC), .ITER(ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .theta (theta),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'h00) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real a;
    int  e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a < 1.0)  begin a = a * 2.0; e--; end
    while (a >= 2.0) begin a = a / 2.0; e++; end
    return {s, 8'(e), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: real arccos of the exact operand value, with the accuracy band by |x|.
  task automatic chk_acos(input string nm, input logic [31:0] xv, input logic [31:0] th,
                          input logic er);
    real xr, rf, d, tol;
    nvec++;
    xr  = f2r(xv);
    rf  = $acos(xr);
    tol = ((xr <= 0.999) && (xr >= -0.999)) ? (1.0 / 1048576.0) : (1.0 / 4096.0);
    d   = f2r(th) - rf;
    if (d < 0.0) d = -d;
    if (er !== 1'b0 || th[30:23] == 8'hff || d > tol) begin
      nerr++;
      $display("FAIL %s: x=%h got theta=%h (%f) err=%b want %f within %e",
               nm, xv, th, f2r(th), er, rf, tol);
    end
  endtask

  // Issue one op from an accepting state; call just after a posedge.
  task automatic do_op(input logic [31:0] xv, output logic [31:0] th, output logic er,
                       output int lat);
    x     = xv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x     = JUNK;
    lat   = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    th = theta;
    er = err;
  endtask

  // Reset in the middle of an op, after mid_edges edges past acceptance.
  task automatic reset_mid(input string nm, input int mid_edges);
    logic [31:0] th;
    logic        er;
    int          lat, nd;
    x = 32'h3f000000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (mid_edges) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk_eq({nm, "_busy"},  32'(busy),  32'h0);
    chk_eq({nm, "_done"},  32'(done),  32'h0);
    chk_eq({nm, "_theta"}, theta,      32'h0);
    chk_eq({nm, "_err"},   32'(err),   32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk_int({nm, "_no_done"}, nd, 0);
    do_op(32'hbf000000, th, er, lat);
    chk_acos({nm, "_next_op"}, 32'hbf000000, th, er);
    chk_int({nm, "_next_lat"}, lat, LAT_N);
  endtask

  logic [31:0] th, ops [0:2], xb;
  logic        er;
  int          lat, cyc, nd;
  logic        prev_done;
  real         xr, prev_th;

  initial begin
    // Specials: exact results, latency LAT_S.
    tbl[0]  = '{32'h3f800000, 1'b1, 32'h00000000, 1'b0};
    tbl[1]  = '{32'hbf800000, 1'b1, 32'h40490fdb, 1'b0};
    tbl[2]  = '{32'h00000000, 1'b1, 32'h3fc90fdb, 1'b0};
    tbl[3]  = '{32'h80000000, 1'b1, 32'h3fc90fdb, 1'b0};
    tbl[4]  = '{32'h00000001, 1'b1, 32'h3fc90fdb, 1'b0};
    tbl[5]  = '{32'h80400000, 1'b1, 32'h3fc90fdb, 1'b0};
    tbl[6]  = '{32'h3f800001, 1'b1, 32'h7fc00000, 1'b1};
    tbl[7]  = '{32'hbf800001, 1'b1, 32'h7fc00000, 1'b1};
    tbl[8]  = '{32'h7fc00000, 1'b1, 32'h7fc00000, 1'b1};
    tbl[9]  = '{32'h7f800000, 1'b1, 32'h7fc00000, 1'b1};
    tbl[10] = '{32'hff800000, 1'b1, 32'h7fc00000, 1'b1};
    tbl[11] = '{32'h40000000, 1'b1, 32'h7fc00000, 1'b1};
    // Normal path: theta checked against the model.
    tbl[12] = '{32'h3f000000, 1'b0, 32'h0, 1'b0};
    tbl[13] = '{32'hbf000000, 1'b0, 32'h0, 1'b0};
    tbl[14] = '{32'h3e800000, 1'b0, 32'h0, 1'b0};
    tbl[15] = '{32'h2b800000, 1'b0, 32'h0, 1'b0};
    tbl[16] = '{32'h3f7fffff, 1'b0, 32'h0, 1'b0};
    tbl[17] = '{32'hbf7fffff, 1'b0, 32'h0, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_eq("rst_busy",  32'(busy), 32'h0);
    chk_eq("rst_done",  32'(done), 32'h0);
    chk_eq("rst_theta", theta,     32'h0);
    chk_eq("rst_err",   32'(err),  32'h0);

    // Table vectors.
    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].x, th, er, lat);
      if (tbl[i].special) begin
        chk_eq($sformatf("tbl%0d_theta", i), th, tbl[i].th);
        chk_eq($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].er));
        chk_int($sformatf("tbl%0d_lat", i), lat, LAT_S);
      end else begin
        chk_acos($sformatf("tbl%0d_theta", i), tbl[i].x, th, er);
        chk_int($sformatf("tbl%0d_lat", i), lat, LAT_N);
      end
    end

    // start held high for three ops; operand changes while busy must be ignored.
    ops[0] = 32'h3f000000;
    ops[1] = 32'hbf000000;
    ops[2] = 32'h3e800000;
    x = ops[0];
    start = 1'b1;
    @(posedge clk); #1;
    x = JUNK;
    cyc = 0;
    nd = 0;
    prev_done = 1'b0;
    while (cyc < 260) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_done) begin
        x = JUNK;
        prev_done = 1'b0;
      end
      if (done) begin
        if (nd < 3) begin
          chk_acos($sformatf("held_op%0d", nd), ops[nd], theta, err);
          chk_int($sformatf("held_cyc%0d", nd), cyc, LAT_N + (LAT_N + 1) * nd);
        end
        nd++;
        if (nd >= 3) start = 1'b0;
        else begin
          x = ops[nd];
          prev_done = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk_int("held_done_count", nd, 3);
    chk_eq("held_idle", 32'(busy), 32'h0);

    // Async reset mid-SQRT and mid-CORDIC.
    @(posedge clk); #1;
    reset_mid("rst_sqrt", 10);
    reset_mid("rst_cordic", 45);

    // Ascending sweep over (-1,1): accuracy plus monotonic non-increase.
    prev_th = 10.0;
    xr = -1.0;
    while (1) begin
      xr = xr + 0.004 + real'($urandom_range(0, 8000)) * 1.0e-6;
      if (xr >= 1.0) break;
      xb = r2f(xr);
      do_op(xb, th, er, lat);
      chk_acos("sweep", xb, th, er);
      nvec++;
      if (f2r(th) > prev_th) begin
        nerr++;
        $display("FAIL monotonic: x=%h theta=%f above previous %f", xb, f2r(th), prev_th);
      end
      prev_th = f2r(th);
    end

    // Random operands across magnitudes, including underflow to m=0.
    for (int i = 0; i < 120; i++) begin
      xb = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 126)), 23'($urandom)};
      do_op(xb, th, er, lat);
      chk_acos("rand", xb, th, er);
      chk_int("rand_lat", lat, LAT_N);
    end

    // Random operands very close to +/-1.
    for (int i = 0; i < 40; i++) begin
      xb = {1'($urandom_range(0, 1)), 8'd126, 23'($urandom_range(32'h7fbe00, 32'h7fffff))};
      do_op(xb, th, er, lat);
      chk_acos("tail", xb, th, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
